// File: rtl/mux_arb_pkg.sv
// Shared types and defaults for the round-robin mux arbiter.
package mux_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int DEF_N = 4;
   localparam int DEF_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority pick: first set request at or after ptr, modulo N.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] cand;

   // Scan from the farthest offset down so the nearest set bit wins last.
   always_comb begin
      found = |req;
      idx   = '0;
      cand  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         cand = ptr + IW'(i);
         if (req[cand]) idx = cand;
      end
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving an N:1 data mux; one word per grant, IDLE bubble between grants.
module rr_mux_arbiter
   import mux_arb_pkg::*;
#(
   parameter int N = DEF_N,
   parameter int W = DEF_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic [N*W-1:0]       data,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [W-1:0]         out_data,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic [N-1:0]         ack
);

   localparam int IW = $clog2(N);

   arb_state_e    state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] gnt_q, gnt_d;
   logic          pick_found;
   logic [IW-1:0] pick_idx;
   logic [W-1:0]  slice [N];

   rr_pick #(.N(N), .IW(IW)) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   for (genvar k = 0; k < N; k++) begin : g_slice
      assign slice[k] = data[k*W +: W];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      out_valid = 1'b0;
      ack       = '0;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               gnt_d   = pick_idx;
               state_d = GRANT;
            end
         end
         GRANT: begin
            out_valid = req[gnt_q];
            if (!req[gnt_q]) begin
               state_d = IDLE;
            end else if (out_ready) begin
               // A coincident reset cancels the transfer, so no ack escapes.
               ack[gnt_q] = ~rst;
               ptr_d      = gnt_q + IW'(1);
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign out_data = (state_q == GRANT) ? slice[gnt_q] : '0;
   assign gnt_idx  = gnt_q;

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters sharing the output mux (N >= 2, power of two).
REQ-002 Parameter W, default 8: data width per requester.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  N  per-requester request; bit k high = requester k has data pending.
REQ-006 data  input  N*W  flattened requester data; slice k = data[k*W +: W].
REQ-007 out_ready  input  1  sink accepts out_data this cycle when high.
REQ-008 out_valid  output  1  out_data holds a valid word from the granted requester.
REQ-009 out_data  output  W  data of the granted requester, selected by the mux.
REQ-010 gnt_idx  output  log2(N)  index of the currently or last granted requester.
REQ-011 ack  output  N  one-hot pulse; bit k high for exactly one cycle when requester k's word transfers.

Function
REQ-012 Two states: IDLE and GRANT.
REQ-013 IDLE: if req != 0, the block selects the first set req bit scanning upward from ptr modulo N, registers it into gnt_idx, and enters GRANT at the next edge; if req == 0, it stays in IDLE.
REQ-014 Arbitration latency: req rising in IDLE at cycle 0 -> out_valid high in cycle 1.
REQ-015 GRANT: out_valid = req[gnt_idx]; out_data = data slice gnt_idx (combinational mux from the held index); gnt_idx is held stable.
REQ-016 Transfer: out_valid && out_ready in GRANT -> ack[gnt_idx] = 1 in the same cycle, ptr <= (gnt_idx + 1) mod N, and the next state is IDLE.
REQ-017 Each transfer is followed by one IDLE bubble cycle; maximum throughput is one word per 2 cycles.
REQ-018 Backpressure: with out_ready low in GRANT, the block stays in GRANT with out_valid, out_data and gnt_idx unchanged while the requester holds req and data.
REQ-019 Withdrawal: req[gnt_idx] low in GRANT -> out_valid low that cycle, no ack, next state IDLE, ptr unchanged.
REQ-020 Requests from other indices arriving during GRANT are ignored until the return to IDLE; there is no preemption.
REQ-021 ptr wraps from N-1 to 0.
REQ-022 Fairness: with all req bits held high, grants cycle 0,1,...,N-1,0.
REQ-023 out_valid, ack and out_data are 0 whenever the state is IDLE.
REQ-024 ack has at most one bit set in any cycle.

Reset
REQ-025 rst high at an edge -> state IDLE, ptr 0, gnt_idx 0 at the next cycle.
REQ-026 Outputs after reset: out_valid 0, ack 0, out_data 0.
REQ-027 Reset during GRANT abandons the grant with no ack pulse and no ptr advance; reset has priority over a coincident transfer.

Structure
REQ-028 Package mux_arb_pkg holds the state enum (IDLE, GRANT) and the default N and W constants.
REQ-029 Sub-module rr_pick: combinational, inputs req[N] and ptr, outputs found and idx; it is the only round-robin priority logic in the design.
REQ-030 The output data selection is a single N:1 mux indexed by gnt_idx; no data storage.

Verification
REQ-031 req=0100, out_ready=1 -> cycle 1: out_valid=1, gnt_idx=2, out_data=data[2], ack=0100; cycle 2: IDLE, out_valid=0.
REQ-032 req=1111 held, out_ready=1 -> ack sequence 0001,0010,0100,1000,0001, one per 2 cycles.
REQ-033 Grant to 1, out_ready low for 5 cycles then high -> out_valid and out_data stable for 5 cycles, single ack=0010 on the 6th.
REQ-034 Grant to 3, req[3] dropped before out_ready -> out_valid falls, no ack, the next grant goes to the lowest set req at or after ptr (ptr unchanged).
REQ-035 ptr=3 after a grant to 2, req=1001 -> grant to 3, then 0 (wrap-around).
REQ-036 rst asserted in GRANT with out_ready=1 in the same cycle -> no ack, next cycle IDLE, gnt_idx=0, out_valid=0.
